// File: rtl/nmr_pkg.sv
// Shared types for the N-modular-redundancy comparator/voter.
// The result struct is sized for the largest legal configuration; users slice it.
package nmr_pkg;
  localparam int NMR_MAX_W  = 64;
  localparam int NMR_MAX_CH = 4;

  localparam logic MODE_CMP  = 1'b0;
  localparam logic MODE_VOTE = 1'b1;

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, REPORT} state_t;

  typedef struct packed {
    logic [NMR_MAX_W-1:0]  voted;
    logic                  match;
    logic                  no_majority;
    logic [NMR_MAX_CH-1:0] fault_mask;
  } vote_result_t;
endpackage

// File: rtl/nmr_vote_core.sv
// Combinational compare/vote over the latched channel words.
// Every decision is derived from per-channel counts of equal present words.
module nmr_vote_core
  import nmr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 3
) (
  input  logic [NCH-1:0][WIDTH-1:0] i_words,
  input  logic [NCH-1:0]            i_present,
  input  logic                      i_mode,
  output vote_result_t              o_res
);
  localparam int         IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [2:0] THR = 3'(NCH / 2 + 1);

  logic [NCH-1:0][2:0] w_eqcnt;
  logic [2:0]          w_npres;
  logic [IW-1:0]       w_low;
  logic [IW-1:0]       w_maj;
  logic [IW-1:0]       w_ref;
  logic                w_has_maj;
  logic                w_distinct;

  always_comb begin
    w_eqcnt = '0;
    w_npres = '0;
    for (int i = 0; i < NCH; i++) begin
      if (i_present[i]) w_npres = w_npres + 3'd1;
      for (int j = 0; j < NCH; j++)
        if (i_present[j] && i_words[j] == i_words[i]) w_eqcnt[i] = w_eqcnt[i] + 3'd1;
    end
  end

  // Downward scan so the lowest-index candidate wins.
  always_comb begin
    w_low      = '0;
    w_maj      = '0;
    w_has_maj  = 1'b0;
    w_distinct = (w_npres >= 3'd2);
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_present[i]) w_low = IW'(i);
      if (i_present[i] && w_eqcnt[i] >= THR) begin
        w_maj     = IW'(i);
        w_has_maj = 1'b1;
      end
      if (i_present[i] && w_eqcnt[i] != 3'd1) w_distinct = 1'b0;
    end
  end

  always_comb begin
    o_res = '0;
    w_ref = (i_mode == MODE_VOTE && w_has_maj) ? w_maj : w_low;
    o_res.voted[WIDTH-1:0] = i_words[w_ref];
    o_res.match = &i_present;
    for (int i = 0; i < NCH; i++) begin
      if (i_present[i] && i_words[i] != i_words[w_low]) o_res.match = 1'b0;
      o_res.fault_mask[i] = !i_present[i] || (i_words[i] != i_words[w_ref]);
    end
    if (i_mode == MODE_CMP && w_distinct)
      o_res.fault_mask[NCH-1:0] = '1;
    if (i_mode == MODE_VOTE && !w_has_maj) begin
      o_res.no_majority         = 1'b1;
      o_res.fault_mask[NCH-1:0] = '1;
    end
  end
endmodule

// File: rtl/nmr_compare_voter.sv
// NMR comparator/voter: latches one word per core, evaluates once, holds the
// result until software acknowledges with all valid flags dropped.
module nmr_compare_voter
  import nmr_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NCH     = 3,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic [NCH-1:0]       data_valid,
  input  logic                 mode,
  input  logic                 ack,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     voted_data,
  output logic                 match,
  output logic                 no_majority,
  output logic [NCH-1:0]       fault_mask,
  output logic                 timeout,
  output logic                 done,
  output logic                 irq,
  output logic [CNT_W-1:0]     mismatch_count
);
  localparam int TW = $clog2(TIMEOUT);

  state_t                    r_state;
  logic [NCH-1:0][WIDTH-1:0] r_words;
  logic [NCH-1:0]            r_present;
  logic                      r_mode;
  logic [TW-1:0]             r_timer;

  logic [NCH-1:0][WIDTH-1:0] w_words;
  vote_result_t              w_res;

  assign w_words = data_in;

  nmr_vote_core #(.WIDTH(WIDTH), .NCH(NCH)) u_vote (
    .i_words  (r_words),
    .i_present(r_present),
    .i_mode   (r_mode),
    .o_res    (w_res)
  );

  if (WIDTH < NMR_MAX_W) begin : g_vpad
    logic w_unused_v;
    assign w_unused_v = |w_res.voted[NMR_MAX_W-1:WIDTH];
  end
  if (NCH < NMR_MAX_CH) begin : g_fpad
    logic w_unused_f;
    assign w_unused_f = |w_res.fault_mask[NMR_MAX_CH-1:NCH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_words        <= '0;
      r_present      <= '0;
      r_mode         <= MODE_CMP;
      r_timer        <= '0;
      voted_data     <= '0;
      match          <= 1'b0;
      no_majority    <= 1'b0;
      fault_mask     <= '0;
      timeout        <= 1'b0;
      done           <= 1'b0;
      irq            <= 1'b0;
      mismatch_count <= '0;
    end else begin
      irq <= 1'b0;

      if (cnt_clr)
        mismatch_count <= '0;
      else if (r_state == EVAL && !w_res.match && mismatch_count != '1)
        mismatch_count <= mismatch_count + CNT_W'(1);

      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (!ack && |data_valid) begin
            r_state   <= COLLECT;
            r_mode    <= mode;
            r_timer   <= '0;
            r_present <= data_valid;
            for (int i = 0; i < NCH; i++)
              if (data_valid[i]) r_words[i] <= w_words[i];
          end
        end
        COLLECT: begin
          // First valid sighting wins; later data on a captured channel is ignored.
          for (int i = 0; i < NCH; i++)
            if (data_valid[i] && !r_present[i]) r_words[i] <= w_words[i];
          r_present <= r_present | data_valid;
          if (&r_present) begin
            r_state <= EVAL;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_state <= EVAL;
            timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        EVAL: begin
          voted_data  <= w_res.voted[WIDTH-1:0];
          match       <= w_res.match;
          no_majority <= w_res.no_majority;
          fault_mask  <= w_res.fault_mask[NCH-1:0];
          done        <= 1'b1;
          irq         <= 1'b1;
          r_state     <= REPORT;
        end
        REPORT: begin
          if (ack && data_valid == '0) begin
            r_state   <= IDLE;
            done      <= 1'b0;
            r_present <= '0;
            timeout   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nmr_compare_voter.sv
// Directed bench for nmr_compare_voter (NCH=3, TIMEOUT=16, CNT_W=2).
module tb_nmr_compare_voter;
  localparam int W = 32;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0] data_valid = '0;
  logic         mode = 1'b0;
  logic         ack = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [W-1:0] voted_data;
  logic         match, no_majority, timeout, done, irq;
  logic [N-1:0] fault_mask;
  logic [1:0]   mismatch_count;

  int checks = 0;
  int errors = 0;

  nmr_compare_voter #(.WIDTH(W), .NCH(N), .TIMEOUT(16), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .mode(mode), .ack(ack), .cnt_clr(cnt_clr), .voted_data(voted_data),
    .match(match), .no_majority(no_majority), .fault_mask(fault_mask),
    .timeout(timeout), .done(done), .irq(irq), .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  // Drive one transaction with all listed channels valid in a single cycle and
  // stop at the first negedge of REPORT.
  task automatic run_simple(input logic m, input logic [W-1:0] w0, w1, w2,
                            input logic [N-1:0] v);
    @(negedge clk); mode = m; data_in = {w2, w1, w0}; data_valid = v;
    @(negedge clk); data_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_txn();
    @(negedge clk); ack = 1'b1; data_valid = '0;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({voted_data, match, no_majority, fault_mask, timeout, done, irq, mismatch_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got voted=%h m=%b nm=%b fm=%b to=%b d=%b irq=%b cnt=%0d want all 0",
               voted_data, match, no_majority, fault_mask, timeout, done, irq, mismatch_count);
    end
  endtask

  task automatic test_vote_all_equal();
    @(negedge clk); mode = 1'b1; data_in = {3{32'hA5A5_0001}}; data_valid = 3'b111;
    @(negedge clk); data_valid = '0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL eq_done_early got %b want 0", done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL eq_done_irq got done=%b irq=%b want 1 1", done, irq);
    end
    checks++;
    if (voted_data !== 32'hA5A5_0001 || match !== 1'b1 || fault_mask !== 3'b000 ||
        no_majority !== 1'b0 || mismatch_count !== 2'd0) begin
      errors++;
      $display("FAIL eq_result got voted=%h m=%b fm=%b nm=%b cnt=%0d want a5a50001 1 000 0 0",
               voted_data, match, fault_mask, no_majority, mismatch_count);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL eq_irq_pulse got irq=%b done=%b want 0 1", irq, done);
    end
    release_txn();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL eq_release got done=%b want 0", done); end
  endtask

  task automatic test_vote_one_bad();
    run_simple(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 3'b111);
    checks++;
    if (voted_data !== 32'h1234_5678 || match !== 1'b0 || fault_mask !== 3'b010 ||
        mismatch_count !== 2'd1) begin
      errors++;
      $display("FAIL vote_one_bad got voted=%h m=%b fm=%b cnt=%0d want 12345678 0 010 1",
               voted_data, match, fault_mask, mismatch_count);
    end
    // ack with valid still high must not release
    @(negedge clk); ack = 1'b1; data_valid = 3'b111;
    @(negedge clk); ack = 1'b0; data_valid = '0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ack_with_valid got done=%b want 1", done); end
    release_txn();
  endtask

  task automatic test_vote_no_majority();
    run_simple(1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 3'b111);
    checks++;
    if (no_majority !== 1'b1 || voted_data !== 32'h0000_0001 || fault_mask !== 3'b111 ||
        match !== 1'b0 || mismatch_count !== 2'd2) begin
      errors++;
      $display("FAIL no_majority got nm=%b voted=%h fm=%b m=%b cnt=%0d want 1 00000001 111 0 2",
               no_majority, voted_data, fault_mask, match, mismatch_count);
    end
    release_txn();
  endtask

  task automatic test_compare_staggered();
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 0) begin mode = 1'b0; data_in = {3{32'h0BAD_F00D}}; data_valid = 3'b001; end
      if (c == 2) data_in[W-1:0] = 32'hFFFF_FFFF;
      if (c == 5) data_valid = 3'b011;
      if (c == 9) data_valid = 3'b111;
      if (c == 11) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL stag_done_early got %b want 0", done); end
      end
      if (c == 12) begin
        checks++;
        if (done !== 1'b1 || irq !== 1'b1 || match !== 1'b1 || voted_data !== 32'h0BAD_F00D ||
            fault_mask !== 3'b000 || mismatch_count !== 2'd2) begin
          errors++;
          $display("FAIL stag_result got d=%b irq=%b m=%b voted=%h fm=%b cnt=%0d want 1 1 1 0badf00d 000 2",
                   done, irq, match, voted_data, fault_mask, mismatch_count);
        end
      end
    end
    release_txn();
  endtask

  task automatic test_timeout();
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      if (c == 0) begin mode = 1'b1; data_in = {32'h0, {2{32'h0000_CAFE}}}; data_valid = 3'b011; end
      if (c == 17) begin
        checks++;
        if (irq !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL to_early got irq=%b done=%b want 0 0", irq, done);
        end
      end
      if (c == 18) begin
        checks++;
        if (irq !== 1'b1 || timeout !== 1'b1 || fault_mask !== 3'b100 || match !== 1'b0 ||
            voted_data !== 32'h0000_CAFE || no_majority !== 1'b0 || mismatch_count !== 2'd3) begin
          errors++;
          $display("FAIL to_result got irq=%b to=%b fm=%b m=%b voted=%h nm=%b cnt=%0d want 1 1 100 0 0000cafe 0 3",
                   irq, timeout, fault_mask, match, voted_data, no_majority, mismatch_count);
        end
      end
    end
    release_txn();
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL to_release got done=%b to=%b want 0 0", done, timeout);
    end
  endtask

  task automatic test_ack_hold();
    @(negedge clk); ack = 1'b1; mode = 1'b1; data_in = {3{32'h1}}; data_valid = 3'b111;
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL ack_hold got done=%b irq=%b want 0 0", done, irq);
    end
    ack = 1'b0; data_valid = '0;
  endtask

  task automatic test_saturation();
    run_simple(1'b1, 32'h5, 32'h5, 32'h6, 3'b111);
    checks++;
    if (mismatch_count !== 2'd3 || fault_mask !== 3'b100) begin
      errors++; $display("FAIL sat_hold got cnt=%0d fm=%b want 3 100", mismatch_count, fault_mask);
    end
    release_txn();
    // cnt_clr lands on the EVAL cycle of another mismatch
    @(negedge clk); mode = 1'b1; data_in = {32'h7, 32'h8, 32'h7}; data_valid = 3'b111;
    @(negedge clk); data_valid = '0;
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    checks++;
    if (mismatch_count !== 2'd0 || done !== 1'b1 || fault_mask !== 3'b010) begin
      errors++;
      $display("FAIL clr_priority got cnt=%0d done=%b fm=%b want 0 1 010", mismatch_count, done, fault_mask);
    end
    release_txn();
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    @(negedge clk); mode = 1'b0; data_in = {3{32'h9}}; data_valid = 3'b001;
    @(negedge clk);
    @(negedge clk); reset = 1'b1; data_valid = '0;
    @(negedge clk); reset = 1'b0;
    checks++;
    if ({voted_data, match, no_majority, fault_mask, timeout, done, irq, mismatch_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid got voted=%h m=%b fm=%b d=%b irq=%b cnt=%0d want all 0",
               voted_data, match, fault_mask, done, irq, mismatch_count);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (irq || done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_irq got activity=%b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_vote_all_equal();
    test_vote_one_bad();
    test_vote_no_majority();
    test_compare_staggered();
    test_timeout();
    test_ack_hold();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nmr_compare_voter.md
# nmr_compare_voter

Parametrised N-modular-redundancy comparator/voter that sits between NCH MicroBlaze cores and the fault-management core on the AXI-lite register bank. It latches one result word per core, then either checks that all copies are equal (compare mode) or takes a majority vote (vote mode). It reports the voted word, a per-core fault mask and a saturating mismatch count, raises a one-cycle interrupt, and holds results until software acknowledges. A per-transaction timeout flags cores that never deliver.

## Interface
- WIDTH, 32, data word width per core
- NCH, 3, number of redundant cores, legal 2..4
- TIMEOUT, 1024, cycles allowed in COLLECT before forced evaluation, ≥2
- CNT_W, 16, mismatch counter width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  NCH*WIDTH  core i word at bits [i*WIDTH +: WIDTH]
- data_valid  in  NCH  per-core "word loaded" level flag
- mode  in  1  0 = compare (all must match), 1 = majority vote; sampled on IDLE→COLLECT
- ack  in  1  software acknowledge level
- cnt_clr  in  1  synchronous clear of mismatch_count
- voted_data  out  WIDTH  result word
- match  out  1  all NCH copies present and equal
- no_majority  out  1  vote mode only: no value held by >NCH/2 cores
- fault_mask  out  NCH  bit i = core i disagreed with voted_data or was missing
- timeout  out  1  evaluation was forced by TIMEOUT
- done  out  1  result valid, held until release
- irq  out  1  one-cycle pulse on result
- mismatch_count  out  CNT_W  saturating count of evaluations with match=0

## Operation
- States: IDLE, COLLECT, EVAL, REPORT.
- Reset: state IDLE. Every output 0, including voted_data, fault_mask and mismatch_count. Channel latches and the present mask clear.
- IDLE: done=0. If ack=0 and any data_valid bit is 1, go to COLLECT, latch mode, clear timer. Words with valid=1 are captured on that same edge.
- COLLECT: each channel is captured once, on the first cycle its valid is seen; later changes are ignored. When all channels are present, go to EVAL. If the timer reaches TIMEOUT-1 with channels still missing, go to EVAL with timeout=1.
- EVAL (1 cycle): register the results, go to REPORT.
  - Compare mode: voted_data = lowest-index present word. match = all present and equal. fault_mask = missing channels | channels ≠ voted_data, except that if all present words differ pairwise, fault_mask = all ones.
  - Vote mode: voted_data = the word held by ≥ NCH/2+1 present channels (integer division). If there is none: no_majority=1, voted_data = lowest-index present word, fault_mask = all ones.
  - mismatch_count += 1 if match=0, saturating at all ones.
- REPORT: done=1, irq=1 only on the entry cycle. Results are held. When ack=1 and data_valid == 0 on the same cycle, go to IDLE. That transition clears done, the present mask and timeout. voted_data, match and fault_mask persist until the next EVAL.
- cnt_clr has priority over the increment when both happen in the same cycle.
- reset mid-transaction: immediate return to IDLE with all outputs zeroed. No irq is issued.

## Timing
- Latency: results, done=1 and irq=1 are visible 2 clocks after the edge that captures the last channel.
- Timeout: evaluation follows TIMEOUT cycles after entering COLLECT, +1 for EVAL.
- IDLE with ack=1 stays IDLE regardless of data_valid, so no re-trigger while software holds ack.
- Release takes effect on the edge ack&&!data_valid is sampled. The earliest next transaction is accepted 1 cycle later.
- NCH=2 in vote mode behaves as compare mode (majority = 2).

## Structure
- Package nmr_pkg:
  - state enum (IDLE, COLLECT, EVAL, REPORT)
  - typedef vote_result_t {voted, match, no_majority, fault_mask}
  - MODE_CMP/MODE_VOTE constants
- Sub-module nmr_vote_core: purely combinational. Takes the NCH words, the present mask and mode; returns vote_result_t using pairwise-equality counts. The FSM, timer, channel latches and counter live in the top.

## Test plan
- NCH=3, vote mode, all words 0xA5A5_0001 with valid=3'b111 in one cycle → done 2 clks later, match=1, fault_mask=000, irq single pulse, count 0.
- Vote mode, core1=0xDEAD_BEEF, others 0x1234_5678 → voted 0x1234_5678, match=0, fault_mask=010, mismatch_count=1.
- Vote mode, three distinct words → no_majority=1, voted = core0 word, fault_mask=111.
- Compare mode, valid bits arriving on cycles 0, 5 and 9 with equal data → evaluation after cycle 9 capture. Changing core0 data after its capture has no effect.
- TIMEOUT=16, core2 never valid → timeout=1, fault_mask=100, irq fires 17 clks after entry. Release with ack=1 and valid=0 returns to IDLE.
- mismatch_count at saturation plus a further mismatch → stays all ones. cnt_clr in the same cycle → 0. reset during COLLECT → all outputs 0, no irq.
